// File: rtl/lamp_pkg.sv
// Shared command codes and FSM state encoding for the lamp command controller.
package lamp_pkg;

    typedef logic [1:0] cmd_t;
    typedef logic [1:0] state_t;

    localparam cmd_t CMD_NOP    = 2'b00;
    localparam cmd_t CMD_ON     = 2'b01;
    localparam cmd_t CMD_OFF    = 2'b10;
    localparam cmd_t CMD_TOGGLE = 2'b11;

    localparam state_t S_OFF  = 2'd0;
    localparam state_t S_ON   = 2'd1;
    localparam state_t S_LOCK = 2'd2;

endpackage

// File: rtl/cycle_timer.sv
// Saturating up-counter: load clears it, enable advances it, done flags LIMIT-1 reached.
module cycle_timer #(
    parameter int CNT_W = 16,
    parameter int LIMIT = 4
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_enable,
    output logic o_done
);

    // A zero limit has no meaningful terminal count; park it at zero.
    localparam logic [CNT_W-1:0] LAST = CNT_W'((LIMIT > 0) ? LIMIT - 1 : 0);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == LAST);

endmodule

// File: rtl/lamp_cmd_ctrl.sv
// Lamp command controller: registered lamp, post-command lockout, optional auto-off.
// Define LAMP_AUTO_OFF_EN to build the auto-off timer; otherwise timeout_pulse is tied low.
module lamp_cmd_ctrl
    import lamp_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [1:0] i_cmd,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    output logic       o_lamp,
    output logic       o_busy,
    output logic       o_timeout_pulse
);

    state_t r_state;
    logic   r_lamp;

    state_t w_state_nxt;
    logic   w_lamp_nxt;
    logic   w_accept_cmd;
    logic   w_lock_done;
    logic   w_expire;

    assign o_cmd_ready  = (r_state != S_LOCK);
    assign o_busy       = (r_state == S_LOCK);
    assign o_lamp       = r_lamp;
    // Accepted NOPs are deliberately invisible: no lamp change, no lockout, no timer clear.
    assign w_accept_cmd = i_cmd_valid && o_cmd_ready && (i_cmd != CMD_NOP);

    cycle_timer #(
        .CNT_W (CNT_W),
        .LIMIT (LOCKOUT_CYCLES)
    ) u_lock_timer (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_load   (w_accept_cmd),
        .i_enable (r_state == S_LOCK),
        .o_done   (w_lock_done)
    );

`ifdef LAMP_AUTO_OFF_EN
    logic w_on_done;
    logic r_timeout_pulse;

    // Timer runs only while lit; any lamp-setting command in the expiry cycle beats the timeout.
    cycle_timer #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_on_timer (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_load   (w_accept_cmd || !r_lamp || w_expire),
        .i_enable (r_lamp),
        .o_done   (w_on_done)
    );

    assign w_expire = r_lamp && w_on_done && !w_accept_cmd;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_expire;
        end
    end

    assign o_timeout_pulse = r_timeout_pulse;
`else
    assign w_expire        = 1'b0;
    assign o_timeout_pulse = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_lamp_nxt  = r_lamp;
        w_state_nxt = r_state;
        if (w_accept_cmd) begin
            case (i_cmd)
                CMD_ON:  w_lamp_nxt = 1'b1;
                CMD_OFF: w_lamp_nxt = 1'b0;
                default: w_lamp_nxt = !r_lamp;
            endcase
            if (LOCKOUT_CYCLES > 0) begin
                w_state_nxt = S_LOCK;
            end else begin
                w_state_nxt = w_lamp_nxt ? S_ON : S_OFF;
            end
        end else begin
            if (w_expire) begin
                w_lamp_nxt = 1'b0;
            end
            if ((r_state != S_LOCK) || w_lock_done) begin
                w_state_nxt = w_lamp_nxt ? S_ON : S_OFF;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_OFF;
            r_lamp  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lamp  <= w_lamp_nxt;
        end
    end

endmodule

// File: tb/tb_lamp_cmd_ctrl.sv
// Scoreboard bench for lamp_cmd_ctrl: two instances (lockout 4 and lockout 0) share stimulus.
// Define LAMP_AUTO_OFF_EN for both DUT and bench to cover the auto-off timer.
module tb_lamp_cmd_ctrl;

    localparam int TO = 10;
`ifdef LAMP_AUTO_OFF_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        bit lamp;
        int lock_left;
        int on_cnt;
        bit pulse;
    } model_t;

    typedef struct {
        logic lamp;
        logic ready;
        logic busy;
        logic pulse;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] cmd;
    logic       cmd_valid;
    logic       ready4, lamp4, busy4, pulse4;
    logic       ready0, lamp0, busy0, pulse0;

    int n_checks;
    int n_fail;
    int cyc;

    model_t m4, m0;
    exp_t   q4[$];
    exp_t   q0[$];

    lamp_cmd_ctrl #(.LOCKOUT_CYCLES(4), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_cmd           (cmd),
        .i_cmd_valid     (cmd_valid),
        .o_cmd_ready     (ready4),
        .o_lamp          (lamp4),
        .o_busy          (busy4),
        .o_timeout_pulse (pulse4)
    );

    lamp_cmd_ctrl #(.LOCKOUT_CYCLES(0), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut0 (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_cmd           (cmd),
        .i_cmd_valid     (cmd_valid),
        .o_cmd_ready     (ready0),
        .o_lamp          (lamp0),
        .o_busy          (busy0),
        .o_timeout_pulse (pulse0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour: lock_left = cycles of lockout still ahead after this edge.
    function automatic model_t step(model_t m, bit v, logic [1:0] c, int lock);
        model_t n;
        n = m;
        n.pulse = 1'b0;
        if (v && (m.lock_left == 0) && (c != 2'b00)) begin
            if (c == 2'b01)      n.lamp = 1'b1;
            else if (c == 2'b10) n.lamp = 1'b0;
            else                 n.lamp = !m.lamp;
            n.lock_left = lock;
            n.on_cnt    = 0;
        end else begin
            if (m.lock_left > 0) n.lock_left = m.lock_left - 1;
            if (AUTO && m.lamp && (m.on_cnt == TO - 1)) begin
                n.lamp   = 1'b0;
                n.pulse  = 1'b1;
                n.on_cnt = 0;
            end else if (m.lamp) begin
                n.on_cnt = m.on_cnt + 1;
            end else begin
                n.on_cnt = 0;
            end
        end
        return n;
    endfunction

    function automatic exp_t to_exp(model_t m);
        exp_t e;
        e.lamp  = m.lamp;
        e.ready = (m.lock_left == 0);
        e.busy  = (m.lock_left != 0);
        e.pulse = m.pulse;
        return e;
    endfunction

    task automatic compare(input string who, input exp_t e,
                           input logic l, input logic r, input logic b, input logic p);
        check($sformatf("%s.lamp@%0d", who, cyc), 32'(l), 32'(e.lamp));
        check($sformatf("%s.ready@%0d", who, cyc), 32'(r), 32'(e.ready));
        check($sformatf("%s.busy@%0d", who, cyc), 32'(b), 32'(e.busy));
        check($sformatf("%s.pulse@%0d", who, cyc), 32'(p), 32'(e.pulse));
    endtask

    // One clock: drive at negedge, push expectations, compare 1 time unit after the edge.
    task automatic cycle(input bit v, input logic [1:0] c);
        exp_t e4, e0;
        @(negedge clk);
        cmd_valid = v;
        cmd       = c;
        m4 = step(m4, v, c, 4);
        m0 = step(m0, v, c, 0);
        q4.push_back(to_exp(m4));
        q0.push_back(to_exp(m0));
        @(posedge clk);
        #1;
        cyc++;
        if (q4.size() == 0 || q0.size() == 0) begin
            check("sb_empty", 32'(q4.size() + q0.size()), 32'd2);
        end else begin
            e4 = q4.pop_front();
            e0 = q0.pop_front();
            compare("lk4", e4, lamp4, ready4, busy4, pulse4);
            compare("lk0", e0, lamp0, ready0, busy0, pulse0);
        end
        cmd_valid = 1'b0;
        cmd       = 2'b00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 2'b00);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        m4        = '{lamp: 1'b0, lock_left: 0, on_cnt: 0, pulse: 1'b0};
        m0        = m4;
        rst       = 1'b1;
        cmd       = 2'b00;
        cmd_valid = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_lamp", 32'(lamp4), 32'd0);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_pulse", 32'(pulse4), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(ready4), 32'd1);
        check("rst_ready0", 32'(ready0), 32'd1);

        // ON then TOGGLEs during lockout (ignored by lk4, accepted every cycle by lk0)
        cycle(1'b1, 2'b01);
        cycle(1'b1, 2'b11);
        cycle(1'b1, 2'b11);
        cycle(1'b1, 2'b11);
        idle(14);

        // TOGGLE pair spaced 5 cycles, starting dark
        cycle(1'b1, 2'b10);
        idle(5);
        cycle(1'b1, 2'b11);
        idle(4);
        cycle(1'b1, 2'b11);
        idle(5);

        // three consecutive TOGGLEs
        cycle(1'b1, 2'b11);
        cycle(1'b1, 2'b11);
        cycle(1'b1, 2'b11);
        idle(6);

        // NOP with lamp lit, redundant ON/OFF still locks out
        cycle(1'b1, 2'b01);
        idle(4);
        cycle(1'b1, 2'b00);
        cycle(1'b1, 2'b00);
        cycle(1'b1, 2'b01);
        idle(4);
        cycle(1'b1, 2'b10);
        idle(4);
        cycle(1'b1, 2'b10);
        idle(5);

        // ON re-issued in the 10th lit cycle, then let the restarted timer run out
        cycle(1'b1, 2'b01);
        idle(9);
        cycle(1'b1, 2'b01);
        idle(14);

        // asynchronous reset in the middle of a lockout with the lamp lit
        cycle(1'b1, 2'b01);
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_lamp", 32'(lamp4), 32'd0);
        check("mid_rst_busy", 32'(busy4), 32'd0);
        check("mid_rst_lamp0", 32'(lamp0), 32'd0);
        m4 = '{lamp: 1'b0, lock_left: 0, on_cnt: 0, pulse: 1'b0};
        m0 = m4;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(ready4), 32'd1);
        cycle(1'b1, 2'b11);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
